// File: rtl/stack_mem_sequencer_if.sv
// Memory request/acknowledge bus between the stack/memory sequencer and its memory.
interface stack_mem_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/stack_mem_sequencer.sv
// Two-port memory access sequencer with PC, downward-growing main/return stack pointers
// and read-data capture registers.
module stack_mem_sequencer #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] MSP_INIT = WIDTH'(16'h7FFF),
  parameter logic [WIDTH-1:0] RSP_INIT = WIDTH'(16'hFFFF),
  parameter int unsigned      DEPTH    = 256
) (
  input  logic                  CLK,
  input  logic                  RegReset,
  input  logic [WIDTH-1:0]      SignExtOut,
  input  logic [WIDTH-1:0]      ZeroExtOut,
  input  logic [WIDTH-1:0]      ResOut,
  input  logic                  PCWrite,
  input  logic                  PCSource,
  input  logic                  PCAdd,
  input  logic [1:0]            MSPOp,
  input  logic [1:0]            RSPOp,
  input  logic                  Start,
  input  logic                  MemRead1,
  input  logic                  MemWrite1,
  input  logic                  MemRead2,
  input  logic                  MemWrite2,
  input  logic [1:0]            MemDst1,
  input  logic [1:0]            MemDst2,
  input  logic [2:0]            MemData,
  input  logic                  IRWrite,
  input  logic                  ValAWrite,
  input  logic                  ValBWrite,
  input  logic                  FaultClear,
  stack_mem_sequencer_if.master mem,
  output logic                  Busy,
  output logic                  Done,
  output logic [WIDTH-1:0]      IROut,
  output logic [WIDTH-1:0]      ValAOut,
  output logic [WIDTH-1:0]      ValBOut,
  output logic [WIDTH-1:0]      PCOut,
  output logic [WIDTH-1:0]      MSPOut,
  output logic [WIDTH-1:0]      RSPOut,
  output logic [3:0]            StackFault
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PORT1 = 2'd1,
    ST_PORT2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic             r_busy, r_done;
  logic             r_mem_req, r_mem_we;
  logic [WIDTH-1:0] r_mem_addr, r_mem_wdata;
  logic             r_mr1, r_mw1, r_mr2, r_mw2, r_irw, r_vaw, r_vbw;
  logic [WIDTH-1:0] r_addr2, r_wdata;
  logic [WIDTH-1:0] r_ir, r_va, r_vb, r_pc, r_msp, r_rsp;
  logic [CW-1:0]    r_mocc, r_rocc;
  logic [3:0]       r_fault;

  logic             w_idle, w_accept, w_ack, w_p1_in, w_p2_in;
  logic [WIDTH-1:0] w_addr1, w_addr2, w_wdata;
  logic [WIDTH-1:0] w_pc_nxt, w_msp_nxt, w_rsp_nxt;
  logic [CW-1:0]    w_mocc_nxt, w_rocc_nxt;
  logic [3:0]       w_fault_set;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && Start;
  // An ack only counts while a request is actually outstanding.
  assign w_ack    = r_mem_req && mem.mem_ack;
  assign w_p1_in  = MemRead1 | MemWrite1;
  assign w_p2_in  = MemRead2 | MemWrite2;

  assign w_addr1 = (MemDst1 == 2'b01) ? r_msp : r_pc;
  assign w_addr2 = (MemDst2 == 2'b01) ? r_rsp : r_msp;

  always_comb begin
    w_wdata = '0;
    case (MemData)
      3'b000:  w_wdata = r_pc;
      3'b001:  w_wdata = ResOut;
      3'b010:  w_wdata = ZeroExtOut;
      3'b011:  w_wdata = r_va;
      default: w_wdata = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RegReset) begin
    if (RegReset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          if (w_p1_in)      w_state_nxt = ST_PORT1;
          else if (w_p2_in) w_state_nxt = ST_PORT2;
          else              w_state_nxt = ST_DONE;
        end
      end
      ST_PORT1: if (w_ack) w_state_nxt = (r_mr2 | r_mw2) ? ST_PORT2 : ST_DONE;
      ST_PORT2: if (w_ack) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Request/bus drive and read-data capture; port 2 request starts the cycle after a port-1 ack.
  always_ff @(posedge CLK or posedge RegReset) begin
    if (RegReset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mr1       <= 1'b0;
      r_mw1       <= 1'b0;
      r_mr2       <= 1'b0;
      r_mw2       <= 1'b0;
      r_irw       <= 1'b0;
      r_vaw       <= 1'b0;
      r_vbw       <= 1'b0;
      r_addr2     <= '0;
      r_wdata     <= '0;
      r_ir        <= '0;
      r_va        <= '0;
      r_vb        <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_mr1   <= MemRead1;
        r_mw1   <= MemWrite1;
        r_mr2   <= MemRead2;
        r_mw2   <= MemWrite2;
        r_irw   <= IRWrite;
        r_vaw   <= ValAWrite;
        r_vbw   <= ValBWrite;
        r_addr2 <= w_addr2;
        r_wdata <= w_wdata;
      end
      if (w_accept && w_p1_in) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= MemWrite1;
        r_mem_addr  <= w_addr1;
        r_mem_wdata <= w_wdata;
      end else if (w_accept && w_p2_in) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= MemWrite2;
        r_mem_addr  <= w_addr2;
        r_mem_wdata <= w_wdata;
      end else if (w_ack) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end else if (r_state == ST_PORT2 && !r_mem_req) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= r_mw2;
        r_mem_addr  <= r_addr2;
        r_mem_wdata <= r_wdata;
      end
      if (w_ack && r_state == ST_PORT1 && r_mr1 && !r_mw1 && r_irw) r_ir <= mem.mem_rdata;
      if (w_ack && r_state == ST_PORT2 && r_mr2 && !r_mw2) begin
        if (r_vaw) r_va <= mem.mem_rdata;
        if (r_vbw) r_vb <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_idle && PCWrite) begin
      if (PCSource)   w_pc_nxt = r_va;
      else if (PCAdd) w_pc_nxt = r_pc + SignExtOut;
      else            w_pc_nxt = r_pc + WIDTH'(1);
    end
  end

  // Stack pointers move only in IDLE; out-of-range ops hold the pointer and flag a fault.
  always_comb begin
    w_msp_nxt   = r_msp;
    w_mocc_nxt  = r_mocc;
    w_rsp_nxt   = r_rsp;
    w_rocc_nxt  = r_rocc;
    w_fault_set = '0;
    if (w_idle) begin
      case (MSPOp)
        2'b01: begin
          if (r_mocc == OCC_FULL) begin
            w_fault_set[1] = 1'b1;
          end else begin
            w_msp_nxt  = r_msp - WIDTH'(1);
            w_mocc_nxt = r_mocc + CW'(1);
          end
        end
        2'b10: begin
          if (r_mocc == '0) begin
            w_fault_set[0] = 1'b1;
          end else begin
            w_msp_nxt  = r_msp + WIDTH'(1);
            w_mocc_nxt = r_mocc - CW'(1);
          end
        end
        default: w_msp_nxt = r_msp;
      endcase
      case (RSPOp)
        2'b01: begin
          if (r_rocc == OCC_FULL) begin
            w_fault_set[3] = 1'b1;
          end else begin
            w_rsp_nxt  = r_rsp - WIDTH'(1);
            w_rocc_nxt = r_rocc + CW'(1);
          end
        end
        2'b10: begin
          if (r_rocc == '0) begin
            w_fault_set[2] = 1'b1;
          end else begin
            w_rsp_nxt  = r_rsp + WIDTH'(1);
            w_rocc_nxt = r_rocc - CW'(1);
          end
        end
        default: w_rsp_nxt = r_rsp;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RegReset) begin
    if (RegReset) begin
      r_pc    <= '0;
      r_msp   <= MSP_INIT;
      r_rsp   <= RSP_INIT;
      r_mocc  <= '0;
      r_rocc  <= '0;
      r_fault <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_msp   <= w_msp_nxt;
      r_rsp   <= w_rsp_nxt;
      r_mocc  <= w_mocc_nxt;
      r_rocc  <= w_rocc_nxt;
      r_fault <= (FaultClear ? 4'b0000 : r_fault) | w_fault_set;
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign Busy          = r_busy;
  assign Done          = r_done;
  assign IROut         = r_ir;
  assign ValAOut       = r_va;
  assign ValBOut       = r_vb;
  assign PCOut         = r_pc;
  assign MSPOut        = r_msp;
  assign RSPOut        = r_rsp;
  assign StackFault    = r_fault;

endmodule

// File: tb/tb_stack_mem_sequencer.sv
// Scoreboard bench: expected memory transactions are queued at Start and checked when the DUT requests.
module tb_stack_mem_sequencer;
  localparam int unsigned W = 16;

  logic         CLK = 1'b0;
  logic         RegReset;
  logic [W-1:0] SignExtOut, ZeroExtOut, ResOut;
  logic         PCWrite, PCSource, PCAdd;
  logic [1:0]   MSPOp, RSPOp;
  logic         Start, MemRead1, MemWrite1, MemRead2, MemWrite2;
  logic [1:0]   MemDst1, MemDst2;
  logic [2:0]   MemData;
  logic         IRWrite, ValAWrite, ValBWrite, FaultClear;
  logic         Busy, Done;
  logic [W-1:0] IROut, ValAOut, ValBOut, PCOut, MSPOut, RSPOut;
  logic [3:0]   StackFault;

  stack_mem_sequencer_if #(.WIDTH(W)) mif ();

  stack_mem_sequencer #(
    .WIDTH(W), .MSP_INIT(16'h7FFF), .RSP_INIT(16'hFFFF), .DEPTH(2)
  ) dut (
    .CLK(CLK), .RegReset(RegReset),
    .SignExtOut(SignExtOut), .ZeroExtOut(ZeroExtOut), .ResOut(ResOut),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .MSPOp(MSPOp), .RSPOp(RSPOp), .Start(Start),
    .MemRead1(MemRead1), .MemWrite1(MemWrite1), .MemRead2(MemRead2), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .FaultClear(FaultClear),
    .mem(mif),
    .Busy(Busy), .Done(Done),
    .IROut(IROut), .ValAOut(ValAOut), .ValBOut(ValBOut),
    .PCOut(PCOut), .MSPOut(MSPOut), .RSPOut(RSPOut), .StackFault(StackFault)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_ctl();
    SignExtOut = '0; ZeroExtOut = '0; ResOut = '0;
    PCWrite = 0; PCSource = 0; PCAdd = 0; MSPOp = 2'b00; RSPOp = 2'b00;
    Start = 0; MemRead1 = 0; MemWrite1 = 0; MemRead2 = 0; MemWrite2 = 0;
    MemDst1 = 2'b00; MemDst2 = 2'b00; MemData = 3'b000;
    IRWrite = 0; ValAWrite = 0; ValBWrite = 0; FaultClear = 0;
  endtask

  task automatic expect_txn(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    sb.push_back(t);
  endtask

  // Memory responder: waits for a request, checks it against the scoreboard, acks after lat cycles.
  task automatic serve(input string tag, input int lat, input logic [W-1:0] rdata);
    txn_t e;
    int   n = 0;
    while (mif.mem_req !== 1'b1 && n < 20) begin tick(); n++; end
    check_val({tag, "_req"}, 32'(mif.mem_req), 32'd1);
    if (mif.mem_req !== 1'b1) return;
    check_val({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_val({tag, "_we"}, 32'(mif.mem_we), 32'(e.we));
    check_val({tag, "_addr"}, 32'(mif.mem_addr), 32'(e.addr));
    if (e.we) check_val({tag, "_wdata"}, 32'(mif.mem_wdata), 32'(e.wdata));
    for (int i = 0; i < lat; i++) begin
      tick();
      check_val({tag, "_hold"}, 32'({mif.mem_req, mif.mem_we, mif.mem_addr}),
                32'({1'b1, e.we, e.addr}));
    end
    mif.mem_rdata = rdata;
    mif.mem_ack   = 1'b1;
    tick();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    check_val({tag, "_drop"}, 32'(mif.mem_req), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (Done !== 1'b1 && n < 10) begin tick(); n++; end
    check_val({tag, "_done"}, 32'(Done), 32'd1);
    check_val({tag, "_busy"}, 32'(Busy), 32'd0);
    tick();
    check_val({tag, "_done1cyc"}, 32'(Done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    clr_ctl();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    RegReset      = 1'b1;
    #3;
    check_val("rst_pc",    32'(PCOut),  32'h0000);
    check_val("rst_msp",   32'(MSPOut), 32'h7FFF);
    check_val("rst_rsp",   32'(RSPOut), 32'hFFFF);
    check_val("rst_stat",  32'({Busy, Done, mif.mem_req, mif.mem_we}), 32'h0);
    check_val("rst_regs",  32'({IROut, ValAOut}), 32'h0);
    check_val("rst_fault", 32'(StackFault), 32'h0);
    tick();
    RegReset = 1'b0;
    tick();

    // PC = 0x0010 via relative add from 0
    PCWrite = 1; PCAdd = 1; SignExtOut = 16'h0010;
    tick(); clr_ctl();
    check_val("pc_setup", 32'(PCOut), 32'h0010);

    // Fetch; PCWrite/MSPOp/Start while busy must be ignored
    MemRead1 = 1; MemDst1 = 2'b00; IRWrite = 1; Start = 1;
    expect_txn(1'b0, 16'h0010, 16'h0);
    tick(); clr_ctl();
    check_val("fetch_busy", 32'(Busy), 32'd1);
    PCWrite = 1; MSPOp = 2'b01; Start = 1;
    serve("fetch", 3, 16'hABCD);
    clr_ctl();
    wait_done("fetch");
    check_val("fetch_ir",   32'(IROut),  32'hABCD);
    check_val("busy_pc",    32'(PCOut),  32'h0010);
    check_val("busy_msp",   32'(MSPOut), 32'h7FFF);

    // Push + port-2 write in the same Start cycle
    MSPOp = 2'b01; MemWrite2 = 1; MemDst2 = 2'b00; MemData = 3'b001; ResOut = 16'h1234; Start = 1;
    expect_txn(1'b1, 16'h7FFF, 16'h1234);
    tick(); clr_ctl();
    check_val("push_msp", 32'(MSPOut), 32'h7FFE);
    serve("push_wr", 1, 16'h0);
    wait_done("push_wr");

    // Two-port read: port1 from MSP into IR, port2 from RSP into ValA and ValB
    MemRead1 = 1; MemDst1 = 2'b01; IRWrite = 1;
    MemRead2 = 1; MemDst2 = 2'b01; ValAWrite = 1; ValBWrite = 1; Start = 1;
    expect_txn(1'b0, 16'h7FFE, 16'h0);
    expect_txn(1'b0, 16'hFFFF, 16'h0);
    tick(); clr_ctl();
    serve("two_p1", 0, 16'h1111);
    serve("two_p2", 2, 16'h2222);
    wait_done("two");
    check_val("two_ir", 32'(IROut),   32'h1111);
    check_val("two_va", 32'(ValAOut), 32'h2222);
    check_val("two_vb", 32'(ValBOut), 32'h2222);

    // Read+write on port 1: write wins, IR untouched; MemDst1=10 selects PC
    MemRead1 = 1; MemWrite1 = 1; IRWrite = 1; MemDst1 = 2'b10; MemData = 3'b011; Start = 1;
    expect_txn(1'b1, 16'h0010, 16'h2222);
    tick(); clr_ctl();
    serve("wwin", 0, 16'hDEAD);
    wait_done("wwin");
    check_val("wwin_ir", 32'(IROut), 32'h1111);

    // Two writes sharing ZeroExtOut data
    MemWrite1 = 1; MemDst1 = 2'b00; MemWrite2 = 1; MemDst2 = 2'b01;
    MemData = 3'b010; ZeroExtOut = 16'h00AB; Start = 1;
    expect_txn(1'b1, 16'h0010, 16'h00AB);
    expect_txn(1'b1, 16'hFFFF, 16'h00AB);
    tick(); clr_ctl();
    serve("zx_p1", 1, 16'h0);
    serve("zx_p2", 0, 16'h0);
    wait_done("zx");

    // Reserved MemData gives zero; MemDst2=11 selects MSP
    MemWrite2 = 1; MemDst2 = 2'b11; MemData = 3'b101; ResOut = 16'h5555; Start = 1;
    expect_txn(1'b1, 16'h7FFE, 16'h0000);
    tick(); clr_ctl();
    serve("rsv", 0, 16'h0);
    wait_done("rsv");

    // PC sources and wraparound
    PCWrite = 1; PCSource = 1; PCAdd = 1;
    tick(); clr_ctl();
    check_val("pc_src", 32'(PCOut), 32'h2222);
    PCWrite = 1; PCAdd = 1; SignExtOut = 16'hDDDC;
    tick(); clr_ctl();
    check_val("pc_fffe", 32'(PCOut), 32'hFFFE);
    PCWrite = 1; PCAdd = 1; SignExtOut = 16'h0003;
    tick(); clr_ctl();
    check_val("pc_wrap", 32'(PCOut), 32'h0001);
    PCWrite = 1;
    tick(); clr_ctl();
    check_val("pc_inc", 32'(PCOut), 32'h0002);

    // Empty Start: Done two cycles later, no request
    Start = 1;
    tick(); clr_ctl();
    check_val("empty_c1", 32'({Busy, Done, mif.mem_req}), 32'b100);
    tick();
    check_val("empty_c2", 32'({Busy, Done, mif.mem_req}), 32'b010);
    tick();
    check_val("empty_c3", 32'({Busy, Done, mif.mem_req}), 32'b000);

    // Stack limits from a clean reset
    #2 RegReset = 1'b1;
    tick(); RegReset = 1'b0;
    MSPOp = 2'b01;
    repeat (3) tick();
    clr_ctl();
    check_val("ovf_msp",   32'(MSPOut),     32'h7FFD);
    check_val("ovf_fault", 32'(StackFault), 32'b0010);
    FaultClear = 1;
    tick(); clr_ctl();
    check_val("fclr", 32'(StackFault), 32'b0000);
    RSPOp = 2'b10;
    repeat (3) tick();
    clr_ctl();
    check_val("unf_rsp",   32'(RSPOut),     32'hFFFF);
    check_val("unf_fault", 32'(StackFault), 32'b0100);
    RSPOp = 2'b10; FaultClear = 1;
    tick(); clr_ctl();
    check_val("fault_wins", 32'(StackFault), 32'b0100);
    FaultClear = 1;
    tick(); clr_ctl();
    MSPOp = 2'b10;
    repeat (3) tick();
    clr_ctl();
    check_val("pop_msp",   32'(MSPOut),     32'h7FFF);
    check_val("pop_fault", 32'(StackFault), 32'b0001);

    // Reset mid-request, then a late ack
    MemRead1 = 1; MemDst1 = 2'b00; IRWrite = 1; Start = 1;
    tick(); clr_ctl();
    check_val("mid_req", 32'(mif.mem_req), 32'd1);
    tick();
    #2 RegReset = 1'b1;
    #1;
    check_val("mid_async", 32'({Busy, Done, mif.mem_req, mif.mem_we}), 32'h0);
    check_val("mid_regs",  32'({StackFault, MSPOut}), 32'h7FFF);
    tick();
    RegReset      = 1'b0;
    mif.mem_rdata = 16'hBEEF;
    mif.mem_ack   = 1'b1;
    tick();
    mif.mem_ack   = 1'b0;
    check_val("late_ack", 32'({IROut, PCOut}), 32'h0);
    check_val("late_stat", 32'({Busy, Done, mif.mem_req}), 32'h0);
    tick();
    check_val("late_done", 32'(Done), 32'd0);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
